// File: rtl/wrr_pkt_arbiter.sv
// Weighted round-robin packet arbiter: N requesters share one downstream port, grant held per packet.
// Latency: one cycle from req to registered grant; back-to-back handover on completion, no idle bubble.
// Backpressure: beat_ready low holds the current owner; only ready&last or owner req drop ends a packet.
module wrr_pkt_arbiter #(
    parameter  int N  = 4,
    parameter  int WW = 4,
    localparam int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*WW-1:0] weight,
    input  logic            beat_ready,
    input  logic            beat_last,
    output logic [N-1:0]    grant,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_valid,
    output logic [WW-1:0]   credit
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_OWN  = 1'b1;

    logic          state_q,  state_d;
    logic [N-1:0]  grant_q,  grant_d;
    logic [IW-1:0] idx_q,    idx_d;
    logic [IW-1:0] ptr_q,    ptr_d;
    logic [WW-1:0] credit_q, credit_d;

    logic          owner_req;
    logic          abort;
    logic          done;
    logic          keep;

    logic [IW-1:0] base;
    logic [N-1:0]  cand;
    logic [N-1:0]  masked;
    logic [IW-1:0] win;
    logic          win_vld;
    logic [WW-1:0] win_weight;
    logic          load;

    // Completion detection for the current owner: accepted last beat, or the owner withdrew its request.
    always_comb begin
        owner_req = req[idx_q];
        abort     = (state_q == S_OWN) && !owner_req;
        done      = (state_q == S_OWN) && beat_ready && beat_last;
        keep      = done && owner_req && (credit_q > WW'(1));
    end

    // Search start and candidate set: from ptr when idle, from owner+1 on handover (aborting owner excluded).
    always_comb begin
        base = ptr_q;
        cand = req;
        if (state_q == S_OWN) begin
            base = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
            if (abort) begin
                cand[idx_q] = 1'b0;
            end
        end
    end

    // Masked/unmasked priority pick: lowest candidate at or above base, else lowest overall (the wrap).
    always_comb begin
        masked  = '0;
        win     = '0;
        win_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            masked[i] = cand[i] && (i >= int'(base));
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win     = IW'(i);
                win_vld = 1'b1;
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (masked[i]) begin
                win = IW'(i);
            end
        end
    end

    // Winner's weight; zero is promoted to one so an owner always gets at least one packet.
    always_comb begin
        win_weight = '0;
        for (int i = 0; i < N; i++) begin
            if (win == IW'(i)) begin
                win_weight = weight[i*WW +: WW];
            end
        end
        if (win_weight == '0) begin
            win_weight = WW'(1);
        end
    end

    // Next-state: idle grant, keep with credit decrement, or release with immediate re-arbitration.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        load     = 1'b0;
        if (state_q == S_IDLE) begin
            load = win_vld;
        end else if (keep) begin
            credit_d = credit_q - WW'(1);
        end else if (abort || done) begin
            ptr_d = base;
            if (win_vld) begin
                load = 1'b1;
            end else begin
                state_d  = S_IDLE;
                grant_d  = '0;
                idx_d    = '0;
                credit_d = '0;
            end
        end
        if (load) begin
            state_d      = S_OWN;
            grant_d      = '0;
            grant_d[win] = 1'b1;
            idx_d        = win;
            credit_d     = win_weight;
        end
    end

    // State registers with synchronous reset; reset drops any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            idx_q    <= '0;
            ptr_q    <= '0;
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = |grant_q;
    assign credit      = credit_q;

endmodule

// File: tb/tb_wrr_pkt_arbiter.sv
// Bench for wrr_pkt_arbiter: directed scenarios plus random traffic against a packet-level model.
// Model tracks owner/pointer/credit as integers and picks winners by scanning from the pointer.
// Outputs are sampled 1ns after each rising edge; inputs change at the same point.
module tb_wrr_pkt_arbiter;

    localparam int N  = 4;
    localparam int WW = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*WW-1:0] weight;
    logic            beat_ready;
    logic            beat_last;
    logic [N-1:0]    grant;
    logic [IW-1:0]   grant_idx;
    logic            grant_valid;
    logic [WW-1:0]   credit;

    always #5 clk = ~clk;

    wrr_pkt_arbiter #(.N(N), .WW(WW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .weight     (weight),
        .beat_ready (beat_ready),
        .beat_last  (beat_last),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid),
        .credit     (credit)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference state: owner index (-1 when idle), rotate pointer, remaining packets.
    int m_own  = -1;
    int m_ptr  = 0;
    int m_cred = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit req_bit(input logic [N-1:0] v, input int i);
        logic [N-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    // First requester at or after 'from', wrapping around N.
    function automatic int pick(input logic [N-1:0] v, input int from);
        for (int k = 0; k < N; k++) begin
            if (req_bit(v, (from + k) % N)) return (from + k) % N;
        end
        return -1;
    endfunction

    function automatic int wt(input logic [N*WW-1:0] w, input int i);
        logic [N*WW-1:0] t;
        int v;
        t = w >> (i * WW);
        v = int'(t[WW-1:0]);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_step(input logic r, input logic [N-1:0] rq, input logic [N*WW-1:0] w,
                              input logic br, input logic bl);
        int o;
        int win;
        logic [N-1:0] c;
        bit ab;
        if (r) begin
            m_own = -1; m_ptr = 0; m_cred = 0;
            return;
        end
        if (m_own < 0) begin
            win = pick(rq, m_ptr);
            if (win >= 0) begin
                m_own = win; m_cred = wt(w, win);
            end
            return;
        end
        ab = !req_bit(rq, m_own);
        if (!(ab || (br && bl))) return;
        if (!ab && m_cred > 1) begin
            m_cred--;
            return;
        end
        o     = m_own;
        m_ptr = (o + 1) % N;
        c     = rq;
        if (ab) c = c & ~(N'(1) << o);
        win = pick(c, m_ptr);
        if (win >= 0) begin
            m_own = win; m_cred = wt(w, win);
        end else begin
            m_own = -1; m_cred = 0;
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare all outputs after the edge.
    task automatic tick(input logic r, input logic [N-1:0] rq, input logic br, input logic bl);
        logic [N-1:0] eg;
        rst = r; req = rq; beat_ready = br; beat_last = bl;
        model_step(r, rq, weight, br, bl);
        @(posedge clk);
        #1;
        eg = '0;
        if (m_own >= 0) eg = N'(1) << m_own;
        check_eq("grant",       32'(grant),       32'(eg));
        check_eq("grant_idx",   32'(grant_idx),   (m_own >= 0) ? 32'(m_own) : 32'd0);
        check_eq("grant_valid", 32'(grant_valid), (m_own >= 0) ? 32'd1 : 32'd0);
        check_eq("credit",      32'(credit),      32'(m_cred));
    endtask

    logic [N-1:0] rr_exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [N-1:0] wr_exp [4] = '{4'b1000, 4'b1000, 4'b1000, 4'b0001};
    logic [3:0]   wr_crd [4] = '{4'd3, 4'd2, 4'd1, 4'd1};
    logic         mb_rdy [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic         mb_lst [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        logic [N-1:0] rq;
        rst = 1'b1; req = '0; weight = 16'h1111; beat_ready = 1'b0; beat_last = 1'b0;

        // Reset with all requesting: nothing granted until release.
        tick(1'b1, 4'b1111, 1'b0, 1'b0);
        tick(1'b1, 4'b1111, 1'b0, 1'b0);
        check_eq("rst_grant",  32'(grant),       32'd0);
        check_eq("rst_credit", 32'(credit),      32'd0);
        check_eq("rst_valid",  32'(grant_valid), 32'd0);
        tick(1'b0, 4'b1111, 1'b0, 1'b0);
        check_eq("first_grant", 32'(grant), 32'b0001);

        // Plain round robin, single-beat packets.
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 4'b1111, 1'b1, 1'b1);
            check_eq("rr_seq", 32'(grant), 32'(rr_exp[i]));
        end

        // Weighted: requester 3 gets three consecutive packets.
        weight = 16'h3111;
        tick(1'b1, 4'b1001, 1'b0, 1'b0);
        tick(1'b0, 4'b1001, 1'b0, 1'b0);
        check_eq("wr_first", 32'(grant), 32'b0001);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 4'b1001, 1'b1, 1'b1);
            check_eq("wr_grant",  32'(grant),  32'(wr_exp[i]));
            check_eq("wr_credit", 32'(credit), 32'(wr_crd[i]));
        end

        // Multi-beat hold with a stalled beat.
        weight = 16'h1111;
        tick(1'b1, 4'b0011, 1'b0, 1'b0);
        tick(1'b0, 4'b0011, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 4'b0011, mb_rdy[i], mb_lst[i]);
            check_eq("mb_hold", 32'(grant), (i < 4) ? 32'b0001 : 32'b0010);
        end

        // Abort by owner 2: hands over to 0 with weight reload, then idles.
        weight = 16'h1112;
        tick(1'b1, 4'b0000, 1'b0, 1'b0);
        tick(1'b0, 4'b0100, 1'b0, 1'b0);
        check_eq("ab_owner", 32'(grant), 32'b0100);
        tick(1'b0, 4'b0001, 1'b0, 1'b0);
        check_eq("ab_grant",  32'(grant),  32'b0001);
        check_eq("ab_credit", 32'(credit), 32'd2);
        tick(1'b0, 4'b0000, 1'b0, 1'b0);
        check_eq("ab_idle", 32'(grant), 32'd0);

        // Zero weight acts as one; sole requester regranted through the wrap.
        weight = 16'h1101;
        tick(1'b1, 4'b0000, 1'b0, 1'b0);
        tick(1'b0, 4'b0010, 1'b0, 1'b0);
        check_eq("w0_credit", 32'(credit), 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 4'b0010, 1'b1, 1'b1);
            check_eq("w0_regrant", 32'(grant),  32'b0010);
            check_eq("w0_recred",  32'(credit), 32'd1);
        end
        // Reset in the middle of a beat, pointer back to 0.
        tick(1'b1, 4'b1111, 1'b1, 1'b0);
        check_eq("mid_rst", 32'(grant), 32'd0);
        tick(1'b0, 4'b1111, 1'b0, 1'b0);
        check_eq("mid_rst_ptr", 32'(grant), 32'b0001);

        // Random traffic against the model.
        rq = 4'b0000;
        for (int c = 0; c < 800; c++) begin
            if (c % 50 == 0) weight = 16'($urandom);
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
            end
            tick(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0, rq,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wrr_pkt_arbiter.md
Name: wrr_pkt_arbiter

Overview:
- Parametrised weighted round-robin arbiter; successor to the single-cycle round-robin arbiter.
- Arbitrates N requesters for a shared downstream port at packet granularity. A grant is held across a multi-beat packet until the last beat is accepted.
- Each winner may issue up to its programmed weight of consecutive packets before the pointer rotates.
- Sits between requesting masters and a shared bus/FIFO write port; the downstream side uses a ready/last handshake.

Parameters:
- N, 4, number of requesters (2..32).
- WW, 4, width of each per-requester weight field.
- IW, $clog2(N), width of grant_idx (derived; not overridable).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  per-requester request level; held by the requester until its last beat is accepted.
- weight  input  N*WW  packed weights; requester i uses bits [i*WW +: WW]. Sampled only when requester i wins arbitration.
- beat_ready  input  1  downstream accepts the current beat this cycle.
- beat_last  input  1  current beat is the final beat of the owner's packet; qualified by beat_ready.
- grant  output  N  registered one-hot grant; all-zero when idle.
- grant_idx  output  IW  binary index of the granted requester; 0 when idle.
- grant_valid  output  1  equals |grant.
- credit  output  WW  packets remaining to the current owner, including the current packet; 0 when idle.

Behaviour:
- Reset (rst=1 at a clk edge): grant=0, grant_idx=0, grant_valid=0, credit=0, rotate pointer ptr=0, state=IDLE. Reset mid-packet aborts the packet silently.
- States: IDLE (no owner) and OWN (one owner latched).
- IDLE:
  - If |req, select the winner as the first set req bit at index >= ptr, wrapping modulo N (masked/unmasked scheme).
  - Next cycle: grant/grant_idx show the winner; state=OWN; credit = weight[winner], with weight 0 treated as 1.
  - Latency from req rise to grant is 1 cycle.
  - If req=0, stay in IDLE.
- OWN, with owner o:
  - Completion event C = beat_ready & beat_last, or req[o]=0 (abort).
  - beat_ready without beat_last: no state change.
  - If no C, grant is held regardless of other requests (no preemption).
- On C:
  - Keep: if credit>1 and req[o]=1 at that edge and the event was not an abort, o keeps the grant next cycle and credit decrements by 1.
  - Otherwise, release:
    - ptr = (o+1) mod N.
    - Arbitrate in the same cycle from the new ptr over the current req vector, excluding req[o] if this was an abort.
    - A winner is granted the next cycle with no idle bubble; credit reloads from the new winner's weight.
    - If no candidate exists: grant=0, credit=0, state=IDLE.
- Sole requester: a lone requester o can be re-granted through the wrap (ptr=o+1 wraps to o). The result is a back-to-back regrant with credit reloaded.
- Pointer and credit update only on a completion event or IDLE grant. ptr is unchanged on reset-free idle cycles.
- Simultaneous events: req edges coincident with C are evaluated with the current-cycle req values.
- grant is always one-hot or zero. It never changes except at completion, abort, reset, or an IDLE-to-OWN transition.
- Arithmetic: credit is WW bits and never underflows. The minimum value while owned is 1.

Test Plan:
- Reset state: assert rst for 2 cycles with req=4'b1111 → grant=0, credit=0, grant_valid=0. First grant after rst release is 4'b0001 (ptr=0), one cycle after release.
- Plain round robin: N=4, all weights=1, req=4'b1111 held, every beat beat_ready=1, beat_last=1 → grant sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, no bubbles.
- Weighted: weights {1,1,1,3} (req0..req3), req=4'b1001, single-beat packets.
  - Start with requester 0 owning (ptr=0) → grant 0001 once, then 1000 three cycles with credit 3,2,1, then 0001.
- Multi-beat hold: req=4'b0011, requester 0 sends 4 beats with beat_ready pattern 1,0,1,1,1 and last on the 4th accepted beat → grant stays 0001 for all 5 cycles. The cycle after beat_last grant=0010. req1 is never granted early.
- Abort: owner 2 drops req mid-packet while req=4'b0101 → next cycle grant=0001 (ptr was 3, wraps to 0). Credit reloads with weight[0]. Grant goes to 0 the cycle after if req=0.
- Weight zero and reset mid-packet: weight[1]=0, sole req1 → credit=1, regranted each packet.
  - rst asserted during a beat → grant=0 next cycle, ptr=0.
